// File: rtl/plate_pkg.sv
// rtl/plate_pkg.sv - plate field codes, widths, word packing and writer FSM types
package plate_pkg;

   typedef enum logic [1:0] {KA = 2'd0, GJ = 2'd1, BR = 2'd2, MH = 2'd3} plate_state_e;

   localparam int STATE_W = 2;
   localparam int DIST_W  = 3;
   localparam int NUM_W   = 3;
   localparam int PLATE_W = 8;

   // Field slices of the packed word, shared with the recognizer's decoder
   localparam int STATE_HI = 7;
   localparam int STATE_LO = 6;
   localparam int DIST_HI  = 5;
   localparam int DIST_LO  = 3;
   localparam int NUM_HI   = 2;
   localparam int NUM_LO   = 0;

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WRITE, S_REJ} wr_fsm_e;
   typedef enum logic {RSN_FULL, RSN_DUP} rej_reason_e;

   function automatic logic [PLATE_W-1:0] plate_pack(input logic [STATE_W-1:0] s,
                                                     input logic [DIST_W-1:0]  d,
                                                     input logic [NUM_W-1:0]   n);
      return {s, d, n};
   endfunction

endpackage

// File: rtl/plate_shadow_ram.sv
// rtl/plate_shadow_ram.sv - local copy of written plate words for the duplicate scan
module plate_shadow_ram
   import plate_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic               clk_i,
   input  logic               we_i,
   input  logic [AW-1:0]      waddr_i,
   input  logic [PLATE_W-1:0] wdata_i,
   input  logic [AW-1:0]      raddr_i,
   output logic [PLATE_W-1:0] rdata_o
);

   logic [PLATE_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/plate_table_writer.sv
// rtl/plate_table_writer.sv - packs plate fields and writes them into the recognizer table
// PLATE_DEDUP_EN builds the shadow table and duplicate scan.
module plate_table_writer
   import plate_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [1:0]    in_state,
   input  logic [2:0]    in_dist,
   input  logic [2:0]    in_num,
   input  logic          clear,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [7:0]    wr_data,
   output logic [AW:0]   count,
   output logic          full,
   output logic          acc,
   output logic          rej_full,
   output logic          rej_dup
);

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   wr_fsm_e            state_q, state_d;
   rej_reason_e        reason_q, reason_d;
   logic [PLATE_W-1:0] word_q, word_d;
   logic [AW:0]        count_q, count_d;
   logic               live;

`ifdef PLATE_DEDUP_EN
   logic [AW-1:0]      idx_q, idx_d;
   logic [PLATE_W-1:0] shadow_rd;

   plate_shadow_ram #(.DEPTH(DEPTH), .AW(AW)) u_shadow (
      .clk_i   (clk),
      .we_i    (wr_en),
      .waddr_i (count_q[AW-1:0]),
      .wdata_i (word_q),
      .raddr_i (idx_q),
      .rdata_o (shadow_rd)
   );
`endif

   // A clear or reset in the current cycle suppresses every strobe and the handshake
   assign live    = !clear && !rst;
   assign full    = (count_q == DEPTH_C);
   assign count   = count_q;
   assign wr_addr = count_q[AW-1:0];
   assign wr_data = word_q;

   always_comb begin
      state_d  = state_q;
      reason_d = reason_q;
      word_d   = word_q;
      count_d  = count_q;
`ifdef PLATE_DEDUP_EN
      idx_d    = idx_q;
`endif
      in_ready = 1'b0;
      wr_en    = 1'b0;
      acc      = 1'b0;
      rej_full = 1'b0;
      rej_dup  = 1'b0;
      if (clear) begin
         state_d = S_IDLE;
         count_d = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               in_ready = live;
               if (in_valid && live) begin
                  word_d = plate_pack(in_state, in_dist, in_num);
                  if (full) begin
                     state_d  = S_REJ;
                     reason_d = RSN_FULL;
                  end
`ifdef PLATE_DEDUP_EN
                  else if (count_q != '0) begin
                     state_d = S_SCAN;
                     idx_d   = '0;
                  end
`endif
                  else begin
                     state_d = S_WRITE;
                  end
               end
            end
`ifdef PLATE_DEDUP_EN
            S_SCAN: begin
               if (shadow_rd == word_q) begin
                  state_d  = S_REJ;
                  reason_d = RSN_DUP;
               end else if ({1'b0, idx_q} == count_q - (AW+1)'(1)) begin
                  state_d = S_WRITE;
               end else begin
                  idx_d = idx_q + AW'(1);
               end
            end
`endif
            S_WRITE: begin
               wr_en   = live;
               acc     = live;
               count_d = count_q + (AW+1)'(1);
               state_d = S_IDLE;
            end
            S_REJ: begin
               rej_full = live && (reason_q == RSN_FULL);
`ifdef PLATE_DEDUP_EN
               rej_dup  = live && (reason_q == RSN_DUP);
`endif
               state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         reason_q <= RSN_FULL;
         word_q   <= '0;
         count_q  <= '0;
`ifdef PLATE_DEDUP_EN
         idx_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         reason_q <= reason_d;
         word_q   <= word_d;
         count_q  <= count_d;
`ifdef PLATE_DEDUP_EN
         idx_q    <= idx_d;
`endif
      end
   end

endmodule

// File: tb/tb_plate_table_writer.sv
// tb/tb_plate_table_writer.sv - scoreboard bench for plate_table_writer
// Dedup-specific expectations follow PLATE_DEDUP_EN.
module tb_plate_table_writer;
   import plate_pkg::*;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] in_state;
   logic [2:0] in_dist;
   logic [2:0] in_num;
   logic       clear;
   logic       wr_en;
   logic [2:0] wr_addr;
   logic [7:0] wr_data;
   logic [3:0] count;
   logic       full;
   logic       acc;
   logic       rej_full;
   logic       rej_dup;

   plate_table_writer #(.DEPTH(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_state (in_state),
      .in_dist  (in_dist),
      .in_num   (in_num),
      .clear    (clear),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .count    (count),
      .full     (full),
      .acc      (acc),
      .rej_full (rej_full),
      .rej_dup  (rej_dup)
   );

   typedef struct {
      int         kind;   // 0 write, 1 rej_full, 2 rej_dup
      logic [2:0] addr;
      logic [7:0] data;
      int         at;
   } ev_t;

   ev_t  exp_q[$];
   ev_t  e;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   hs_cyc   = 0;
   int   mkind;
   int   h1, h2;
   bit   prev_wr  = 0;

`ifdef PLATE_DEDUP_EN
   localparam bit DEDUP = 1'b1;
`else
   localparam bit DEDUP = 1'b0;
`endif

   initial clk = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog expired cyc=%0d", cyc);
      $fatal(1);
   end

   // Monitor: every strobe must match the head of the expected queue
   always @(negedge clk) begin
      if (wr_en === 1'b1 || rej_full === 1'b1 || rej_dup === 1'b1 || acc === 1'b1) begin
         mkind = (wr_en === 1'b1) ? 0 : (rej_full === 1'b1) ? 1 : 2;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event kind=%0d wr_en=%b rej_full=%b rej_dup=%b acc=%b cyc=%0d",
                     mkind, wr_en, rej_full, rej_dup, acc, cyc);
         end else begin
            e = exp_q.pop_front();
            if (mkind != e.kind || (int'(wr_en) + int'(rej_full) + int'(rej_dup)) != 1 ||
                acc !== wr_en || cyc != e.at ||
                (mkind == 0 && (wr_addr !== e.addr || wr_data !== e.data)))
               begin
                  failures++;
                  $display("FAIL event actual kind=%0d addr=%0d data=%h acc=%b cyc=%0d required kind=%0d addr=%0d data=%h cyc=%0d",
                           mkind, wr_addr, wr_data, acc, cyc, e.kind, e.addr, e.data, e.at);
               end
         end
      end
      if (wr_en === 1'b1 && prev_wr) begin
         checks++;
         failures++;
         $display("FAIL wr_en_back_to_back actual=1 required=0 cyc=%0d", cyc);
      end
      prev_wr = (wr_en === 1'b1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic expect_ev(input int kind, input logic [2:0] addr, input logic [7:0] data, input int rel);
      exp_q.push_back('{kind, addr, data, hs_cyc + rel - 1});
   endtask

   task automatic push(input logic [7:0] w);
      int t;
      t = 0;
      in_state = w[7:6];
      in_dist  = w[5:3];
      in_num   = w[2:0];
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (in_ready !== 1'b1) chk("push_ready_timeout", 32'(in_ready), 32'h1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      hs_cyc   = cyc;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (in_ready !== 1'b1) chk("idle_timeout", 32'(in_ready), 32'h1);
   endtask

   task automatic clear_table();
      @(negedge clk);
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] w;
      rst = 1'b1; clear = 1'b0; in_valid = 1'b0;
      in_state = '0; in_dist = '0; in_num = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_ready", 32'(in_ready), 32'h0);
      chk("reset_wr_en", 32'(wr_en), 32'h0);
      chk("reset_wr_addr", 32'(wr_addr), 32'h0);
      chk("reset_wr_data", 32'(wr_data), 32'h0);
      chk("reset_count", 32'(count), 32'h0);
      chk("reset_full", 32'(full), 32'h0);
      chk("reset_pulses", {29'b0, acc, rej_full, rej_dup}, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", 32'(in_ready), 32'h1);

      // (GJ,1,1) -> 8'h49 at address 0
      push(8'h49);
      expect_ev(0, 3'd0, 8'h49, 1);
      @(negedge clk);
      chk("busy_during_write", 32'(in_ready), 32'h0);
      @(negedge clk);
      chk("count_after_first", 32'(count), 32'h1);
      chk("ready_after_first", 32'(in_ready), 32'h1);

      // clear wins over a simultaneous handshake
      @(negedge clk);
      clear = 1'b1; in_valid = 1'b1; in_state = 2'd1;
      #1;
      chk("ready_low_on_clear", 32'(in_ready), 32'h0);
      @(posedge clk);
      #1;
      clear = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("count_after_clear", 32'(count), 32'h0);
      push(8'h92);
      expect_ev(0, 3'd0, 8'h92, 1);
      wait_idle();
      chk("count_after_br22", 32'(count), 32'h1);

      // Same word twice back to back
      clear_table();
      push(8'hFF);
      h1 = hs_cyc;
      expect_ev(0, 3'd0, 8'hFF, 1);
      push(8'hFF);
      h2 = hs_cyc;
      if (DEDUP) expect_ev(2, 3'd0, 8'h00, 2);
      else       expect_ev(0, 3'd1, 8'hFF, 1);
      chk("handshake_spacing", 32'(h2 - h1), 32'd2);
      wait_idle();
      chk("count_after_repeat", 32'(count), DEDUP ? 32'd1 : 32'd2);

      // Fill all eight entries, then overflow
      clear_table();
      for (int i = 0; i < 8; i++) begin
         w = {2'(i), 3'(i), 3'(i)};
         push(w);
         expect_ev(0, 3'(i), w, DEDUP ? i + 1 : 1);
         wait_idle();
      end
      chk("count_full", 32'(count), 32'd8);
      chk("full_flag", 32'(full), 32'h1);
      push(8'hFF);
      expect_ev(1, 3'd0, 8'h00, 1);
      wait_idle();
      chk("count_after_rej_full", 32'(count), 32'd8);
      chk("full_after_rej_full", 32'(full), 32'h1);

      // Reset while an entry is in flight
      clear_table();
      for (int i = 0; i < 5; i++) begin
         w = {2'(i), 3'(i), 3'(i)};
         push(w);
         expect_ev(0, 3'(i), w, DEDUP ? i + 1 : 1);
         wait_idle();
      end
      push(8'hFF);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("count_after_midreset", 32'(count), 32'h0);
      chk("ready_after_midreset", 32'(in_ready), 32'h1);
      chk("full_after_midreset", 32'(full), 32'h0);

`ifdef PLATE_DEDUP_EN
      clear_table();
      push(8'h00);
      expect_ev(0, 3'd0, 8'h00, 1);
      wait_idle();
      push(8'h92);
      expect_ev(0, 3'd1, 8'h92, 2);
      wait_idle();
      push(8'h00);
      expect_ev(2, 3'd0, 8'h00, 2);
      wait_idle();
      chk("count_after_dup", 32'(count), 32'd2);
`endif

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/plate_table_writer.md
# plate_table_writer

Loads licence-plate codes into the 8-entry plate table that the plate recognizer fetches and decodes. Takes decoded fields (state, district, vehicle number) over a valid/ready handshake and packs them into the 8-bit plate word {state[1:0], dist[2:0], num[2:0]}. Optionally rejects duplicates, then issues a single-cycle write to the recognizer's table write port. It sits upstream of the recognizer, on the host/configuration side.

## Interface
Parameters:
- DEPTH, 8, number of table entries; power of two, 2..256.
- AW, $clog2(DEPTH), table address width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  field set presented.
- in_ready  out  1  writer can accept a field set.
- in_state  in  2  state code: KA=0, GJ=1, BR=2, MH=3.
- in_dist  in  3  district, 0..7.
- in_num  in  3  vehicle number, 0..7.
- clear  in  1  empty the table; entry count returns to 0.
- wr_en  out  1  table write strobe, one cycle per accepted entry.
- wr_addr  out  AW  table write address.
- wr_data  out  8  packed plate word.
- count  out  AW+1  valid entries in the table, 0..DEPTH.
- full  out  1  count == DEPTH.
- acc  out  1  one-cycle pulse when an entry is written.
- rej_full  out  1  one-cycle pulse when an entry is dropped because the table is full.
- rej_dup  out  1  one-cycle pulse when an entry is dropped as a duplicate.

## Operation
- FSM states: IDLE, SCAN, WRITE, REJ.
- in_ready = (state==IDLE) && !clear && !rst. This is combinational from the state register.
- IDLE, handshake (in_valid && in_ready):
  - Capture word = {in_state, in_dist, in_num}.
  - If full, go to REJ with reason FULL.
  - Else, with dedup enabled and count>0, go to SCAN with index 0.
  - Otherwise go to WRITE.
- SCAN:
  - Compare word with shadow[index], one entry per cycle.
  - On a match, go to REJ with reason DUP.
  - If index==count-1 with no match, go to WRITE.
  - Otherwise increment index.
- WRITE:
  - Drive wr_en=1, wr_addr=count[AW-1:0], wr_data=word, acc=1.
  - Write shadow[count]=word and increment count.
  - Return to IDLE.
- REJ: pulse rej_full or rej_dup for one cycle, then return to IDLE. Table and count are unchanged.
- Shadow table: a local copy of written words, used only for the duplicate scan. The writer never reads the recognizer's table.
- clear:
  - Sampled in every state.
  - Forces IDLE and count=0.
  - Aborts any in-progress entry: no wr_en, no acc/rej pulse.
  - Takes priority over a simultaneous handshake; in_ready is low, so nothing is accepted that cycle.
  - Shadow contents need not be cleared, because count bounds the scan.
- Any in_state value 0..3 is legal. No field validation is performed.

## Timing
- Reset values (registered, after the first clock with rst=1):
  - state=IDLE, count=0, full=0.
  - wr_en=0, wr_addr=0, wr_data=0.
  - acc=0, rej_full=0, rej_dup=0.
- Handshake at edge T, no dedup: wr_en/acc high during cycle T+1; in_ready high again from T+2.
- With dedup and k=count>0: SCAN occupies cycles T+1..T+k. wr_en is at T+k+1 on a miss, or rej_dup at T+j+2 on a match at index j.
- Full rejection: rej_full during cycle T+1; in_ready high from T+2.
- Throughput: at most one entry per 2 cycles (no dedup), or per k+2 cycles (with dedup).
- wr_en is never high two consecutive cycles. wr_en, rej_full and rej_dup are mutually exclusive.
- count and full update in the cycle after wr_en, i.e. visible together with in_ready returning high.
- rst mid-operation drops the captured word with no write.

## Configuration
- PLATE_DEDUP_EN defined: the SCAN state and duplicate check are present, and rej_dup can pulse.
- PLATE_DEDUP_EN undefined:
  - SCAN is not built and the shadow table is omitted.
  - rej_dup is tied to 0.
  - Every non-full handshake goes directly to WRITE.

## Structure
- Shared package plate_pkg holds:
  - state codes KA/GJ/BR/MH.
  - field widths (STATE_W=2, DIST_W=3, NUM_W=3, PLATE_W=8).
  - pack function fields→word, and unpack field-slice constants [7:6]/[5:3]/[2:0], shared with the recognizer.
- One sub-module, plate_shadow_ram: DEPTH×8 register array with a synchronous write port and an asynchronous read by index. It is instantiated only under PLATE_DEDUP_EN.

## Test plan
- Reset, then push (GJ,1,1) → wr_en at T+1 with wr_addr=0, wr_data=8'h49, acc=1; count=1 at T+2.
- Dedup on: push 8'h00, 8'h92, then 8'h00 again → two writes (addr 0,1), then rej_dup, no wr_en, count stays 2.
- Fill 8 distinct entries, then push (MH,7,7) → full=1, rej_full pulse one cycle after handshake, no wr_en, count=8.
- clear asserted in the same cycle as in_valid → in_ready=0, no write, count=0 next cycle. Then push (BR,2,2) → wr_addr=0, wr_data=8'h92.
- count=5, push a new word and assert rst during SCAN → no wr_en/pulses; after reset count=0, in_ready=1.
- Dedup off: push the same word 8'hFF twice back-to-back → writes at addr 0 and 1, rej_dup never asserted, handshakes 2 cycles apart.
